vga_timing_engine: RTL and testbench

VGA_TIMING_ENGINE -- requirements
Module: vga_timing_engine

---
 rtl/vga_timing_engine.sv | 130 +++++++++++++
 tb/tb_vga_timing_engine.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_engine.sv
// VGA raster timing generator: h/v counters, a pixel request/coordinate port for a
// latency-PIPE_LAT colour provider, and a flag delay line that aligns sync/strobes with RGB.
module vga_timing_engine #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HSYNC_POL = 1,
    parameter int VSYNC_POL = 1,
    parameter int PIPE_LAT  = 1,
    parameter int CW        = 16,
    parameter int CDW       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    input  logic             blank,
    output logic             req,
    output logic [CW-1:0]    x,
    output logic [CW-1:0]    y,
    input  logic [3*CDW-1:0] color,
    output logic [CDW-1:0]   red,
    output logic [CDW-1:0]   green,
    output logic [CDW-1:0]   blue,
    output logic             de,
    output logic             hsync,
    output logic             vsync,
    output logic             sof,
    output logic             eol
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int LAST    = PIPE_LAT - 1;

    if (H_TOTAL >= (1 << CW)) begin : g_h_range
        $error("H_TOTAL does not fit in CW bits");
    end
    if (V_TOTAL >= (1 << CW)) begin : g_v_range
        $error("V_TOTAL does not fit in CW bits");
    end
    if (PIPE_LAT < 1 || PIPE_LAT > 8) begin : g_lat_range
        $error("PIPE_LAT must be in 1..8");
    end

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_EOL    = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          HS_ON    = (HSYNC_POL != 0);
    localparam logic          VS_ON    = (VSYNC_POL != 0);

    logic [CW-1:0] h;
    logic [CW-1:0] v;
    logic          raw_de;
    logic          raw_hs;
    logic          raw_vs;
    logic          raw_sof;
    logic          raw_eol;
    logic [4:0]    raw_flags;
    logic          gate;

    // Flag stages, bit order {de, hs, vs, sof, eol}; the output registers form the final stage.
    logic [4:0]    stg [PIPE_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (pix_en) begin
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end
        end
    end

    assign raw_de    = (h < H_ACT) && (v < V_ACT);
    assign raw_hs    = (h >= HS_START) && (h < HS_END);
    assign raw_vs    = (v >= VS_START) && (v < VS_END);
    assign raw_sof   = (h == '0) && (v == '0);
    assign raw_eol   = (h == H_EOL) && (v < V_ACT);
    assign raw_flags = {raw_de, raw_hs, raw_vs, raw_sof, raw_eol};

    assign req = raw_de;
    assign x   = raw_de ? h : '0;
    assign y   = raw_de ? v : '0;

    // Blank gates both the colour and de at the edge that registers them.
    assign gate = stg[LAST][4] && !blank;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                stg[i] <= '0;
            end
            red   <= '0;
            green <= '0;
            blue  <= '0;
            de    <= 1'b0;
            hsync <= ~HS_ON;
            vsync <= ~VS_ON;
            sof   <= 1'b0;
            eol   <= 1'b0;
        end else if (pix_en) begin
            stg[0] <= raw_flags;
            for (int i = 1; i < PIPE_LAT; i++) begin
                stg[i] <= stg[i-1];
            end
            {red, green, blue} <= color & {(3*CDW){gate}};
            de    <= gate;
            hsync <= stg[LAST][3] ? HS_ON : ~HS_ON;
            vsync <= stg[LAST][2] ? VS_ON : ~VS_ON;
            sof   <= stg[LAST][1];
            eol   <= stg[LAST][0];
        end
    end

endmodule

// File: tb/tb_vga_timing_engine.sv
// Bench for vga_timing_engine: a small-raster PIPE_LAT=3 instance and a default instance,
// both checked every cycle against an index-arithmetic raster model.
module tb_vga_timing_engine;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, hp, vp, lat;
    } tim_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_en;
    logic        blank;

    logic        req_a, de_a, hsync_a, vsync_a, sof_a, eol_a;
    logic [15:0] x_a, y_a;
    logic [23:0] color_a;
    logic [7:0]  red_a, green_a, blue_a;

    logic        req_b, de_b, hsync_b, vsync_b, sof_b, eol_b;
    logic [15:0] x_b, y_b;
    logic [23:0] color_b;
    logic [7:0]  red_b, green_b, blue_b;

    int          total  = 0;
    int          passed = 0;
    int          k      = 0;
    logic        last_bl = 1'b0;
    tim_t        ta, tb;
    logic [23:0] pa0, pa1, pa2;

    always #5 clk = ~clk;

    vga_timing_engine #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HSYNC_POL(0), .VSYNC_POL(1), .PIPE_LAT(3), .CW(16), .CDW(8)
    ) dut_a (
        .clk(clk), .rst(rst), .pix_en(pix_en), .blank(blank),
        .req(req_a), .x(x_a), .y(y_a), .color(color_a),
        .red(red_a), .green(green_a), .blue(blue_a),
        .de(de_a), .hsync(hsync_a), .vsync(vsync_a), .sof(sof_a), .eol(eol_a)
    );

    vga_timing_engine dut_b (
        .clk(clk), .rst(rst), .pix_en(pix_en), .blank(blank),
        .req(req_b), .x(x_b), .y(y_b), .color(color_b),
        .red(red_b), .green(green_b), .blue(blue_b),
        .de(de_b), .hsync(hsync_b), .vsync(vsync_b), .sof(sof_b), .eol(eol_b)
    );

    // Outputs after k enabled edges: counters sit at raster index k, registered
    // outputs show raster index k-(lat+1); before that they still hold reset values.
    function automatic logic [63:0] model(input tim_t t, input int kk, input logic bl);
        int ht, vt, ft, c, h, v, j, hj, vj;
        logic rq, act, de_e, hs_e, vs_e, sof_e, eol_e;
        logic [15:0] xe, ye;
        logic [7:0] xb, yb;
        logic [23:0] rgb;
        ht = t.ha + t.hf + t.hs + t.hb;
        vt = t.va + t.vf + t.vs + t.vb;
        ft = ht * vt;
        c  = kk % ft;
        h  = c % ht;
        v  = c / ht;
        rq = (h < t.ha) && (v < t.va);
        xe = rq ? 16'(h) : 16'd0;
        ye = rq ? 16'(v) : 16'd0;
        de_e = 1'b0; sof_e = 1'b0; eol_e = 1'b0; rgb = 24'h0;
        hs_e = (t.hp == 0);
        vs_e = (t.vp == 0);
        if (kk >= t.lat + 1) begin
            j  = (kk - t.lat - 1) % ft;
            hj = j % ht;
            vj = j / ht;
            act   = (hj < t.ha) && (vj < t.va);
            de_e  = act && !bl;
            hs_e  = ((hj >= t.ha + t.hf) && (hj < t.ha + t.hf + t.hs)) == (t.hp != 0);
            vs_e  = ((vj >= t.va + t.vf) && (vj < t.va + t.vf + t.vs)) == (t.vp != 0);
            sof_e = (hj == 0) && (vj == 0);
            eol_e = (hj == t.ha - 1) && (vj < t.va);
            xb  = 8'(hj);
            yb  = 8'(vj);
            rgb = de_e ? {xb, yb, 8'h5A} : 24'h0;
        end
        return {2'b00, rq, xe, ye, de_e, hs_e, vs_e, sof_e, eol_e, rgb};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s k=%0d actual=%h required=%h", name, k, act, exp);
    endtask

    task automatic compare();
        chk("dut_a", {2'b00, req_a, x_a, y_a, de_a, hsync_a, vsync_a, sof_a, eol_a,
                      red_a, green_a, blue_a}, model(ta, k, last_bl));
        chk("dut_b", {2'b00, req_b, x_b, y_b, de_b, hsync_b, vsync_b, sof_b, eol_b,
                      red_b, green_b, blue_b}, model(tb, k, last_bl));
    endtask

    // One clock: providers respond to the coordinates present before the edge.
    task automatic step();
        logic [15:0] xa_s, ya_s, xb_s, yb_s;
        logic en, bl, r;
        xa_s = x_a; ya_s = y_a; xb_s = x_b; yb_s = y_b;
        en = pix_en; bl = blank; r = rst;
        @(posedge clk);
        #1;
        if (en && !r) begin
            k++;
            last_bl = bl;
            pa2 = pa1;
            pa1 = pa0;
            pa0 = {xa_s[7:0], ya_s[7:0], 8'h5A};
            color_a = pa2;
            color_b = {xb_s[7:0], yb_s[7:0], 8'h5A};
        end
        compare();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        k   = 0;
        #1;
        compare();
        chk("midrst_hsync_a", {63'd0, hsync_a}, 64'd1);
        chk("midrst_rgb_b", {40'd0, red_b, green_b, blue_b}, 64'd0);
        step();
        step();
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            pix_en = 1'b1;
            blank  = 1'b0;
            step();
            if (i == 3) chk("sof_a_before", {63'd0, sof_a}, 64'd0);
            if (i == 4) chk("sof_a_after_release", {62'd0, sof_a, de_a}, 64'd3);
        end
    endtask

    initial begin
        int cnt_req_b, cnt_hs_b, cnt_eol_b, cnt_vs_a, cnt_hslow_a, cnt_sof_a;
        ta = '{16, 4, 6, 6, 8, 2, 2, 3, 0, 1, 3};
        tb = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 1, 1};
        rst = 1'b1; pix_en = 1'b0; blank = 1'b0;
        color_a = '0; color_b = '0; pa0 = '0; pa1 = '0; pa2 = '0;
        cnt_req_b = 0; cnt_hs_b = 0; cnt_eol_b = 0;
        cnt_vs_a = 0; cnt_hslow_a = 0; cnt_sof_a = 0;
        repeat (3) @(posedge clk);
        #1;
        compare();
        chk("rst_syncs", {60'd0, hsync_a, vsync_a, hsync_b, vsync_b}, 64'h8);
        rst = 1'b0;

        // Continuous enable: pin line/frame figures with hand-computed counts.
        for (int n = 0; n < 800; n++) begin
            pix_en = 1'b1;
            blank  = 1'b0;
            step();
            cnt_req_b += int'(req_b);
            cnt_hs_b  += int'(hsync_b);
            cnt_eol_b += int'(eol_b);
            if (k <= 480) begin
                cnt_vs_a    += int'(vsync_a);
                cnt_hslow_a += int'(!hsync_a);
                cnt_sof_a   += int'(sof_a);
            end
            if (k == 4) chk("first_pixel_a", {38'd0, de_a, sof_a, red_a, green_a, blue_a},
                            {38'd0, 1'b1, 1'b1, 24'h00005A});
        end
        chk("req_per_line_b", 64'(cnt_req_b), 64'd640);
        chk("hsync_per_line_b", 64'(cnt_hs_b), 64'd96);
        chk("eol_per_line_b", 64'(cnt_eol_b), 64'd1);
        chk("vsync_per_frame_a", 64'(cnt_vs_a), 64'd64);
        chk("hsync_low_per_frame_a", 64'(cnt_hslow_a), 64'd90);
        chk("sof_per_frame_a", 64'(cnt_sof_a), 64'd1);

        // Alternating enable: every other clock holds.
        for (int n = 0; n < 200; n++) begin
            pix_en = n[0];
            blank  = 1'b0;
            step();
        end

        // Random enable and blank, with a mid-frame reset partway through.
        for (int n = 0; n < 6000; n++) begin
            if (n == 3000) do_reset();
            pix_en = ($urandom_range(0, 3) != 0);
            blank  = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
